// File: rtl/ping_pong_counter_pkg.sv
// Shared constants for the ping-pong counter slice: direction encodings and default width.
package pp_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/ping_pong_counter_if.sv
// Control/status bundle between the counter and whatever drives its tick, bounds and flip inputs.
interface ping_pong_counter_if
    import pp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             tick;
    logic             enable;
    logic             flip;
    logic [WIDTH-1:0] max;
    logic [WIDTH-1:0] min;
    logic             direction;
    logic [WIDTH-1:0] out;
    logic             stepped;

    modport slave (
        input  tick,
        input  enable,
        input  flip,
        input  max,
        input  min,
        output direction,
        output out,
        output stepped
    );

    modport master (
        output tick,
        output enable,
        output flip,
        output max,
        output min,
        input  direction,
        input  out,
        input  stepped
    );

endinterface

// File: rtl/ping_pong_counter_rise_detect.sv
// Rising-edge detector for a level sampled as data in the clk domain.
module rise_detect
    import pp_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic pulse
);

    logic prevLevel_q;

    // Resetting to 1 means a level already high when reset releases is not seen as an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prevLevel_q <= 1'b1;
        end else begin
            prevLevel_q <= in;
        end
    end

    assign pulse = in & ~prevLevel_q;

endmodule

// File: rtl/ping_pong_counter.sv
// Bounded up/down counter that steps once per tick rise and bounces between min and max.
module ping_pong_counter
    import pp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    ping_pong_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             tickRise;
    logic             legal;
    logic             step;
    logic             effDir;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             direction_q;
    logic             direction_d;
    logic             flipPend_q;
    logic             flipPend_d;
    logic             stepped_q;

    rise_detect u_tickRise (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (bus.tick),
        .pulse (tickRise)
    );

    // Out-of-range counts freeze rather than clamp, so bounds moving under the count stall it.
    assign legal  = (bus.max > bus.min) & (out_q >= bus.min) & (out_q <= bus.max);
    assign step   = tickRise & bus.enable & legal;
    assign effDir = direction_q ^ (flipPend_q | bus.flip);

    always_comb begin
        out_d       = out_q;
        direction_d = direction_q;
        flipPend_d  = flipPend_q | bus.flip;
        if (step) begin
            flipPend_d = 1'b0;
            if (effDir == DIR_UP) begin
                if (out_q == bus.max) begin
                    direction_d = DIR_DOWN;
                    out_d       = out_q - ONE;
                end else begin
                    direction_d = DIR_UP;
                    out_d       = out_q + ONE;
                end
            end else begin
                if (out_q == bus.min) begin
                    direction_d = DIR_UP;
                    out_d       = out_q + ONE;
                end else begin
                    direction_d = DIR_DOWN;
                    out_d       = out_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q       <= bus.min;
            direction_q <= DIR_UP;
            flipPend_q  <= 1'b0;
            stepped_q   <= 1'b0;
        end else begin
            out_q       <= out_d;
            direction_q <= direction_d;
            flipPend_q  <= flipPend_d;
            stepped_q   <= step;
        end
    end

    assign bus.out       = out_q;
    assign bus.direction = direction_q;
    assign bus.stepped   = stepped_q;

endmodule

// File: tb/tb_ping_pong_counter.sv
// Directed self-checking bench for ping_pong_counter with hand-computed count sequences.
module tb_ping_pong_counter;

    import pp_pkg::*;

    logic clk;
    logic rstN;
    int   checkCount;
    int   errorCount;

    ping_pong_counter_if #(.WIDTH(4)) ppIf ();

    ping_pong_counter #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rstN),
        .bus   (ppIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic clockCycle();
        @(posedge clk);
        #1;
    endtask

    // One tick period: tick high for highCycles then low; a step shows on the rise cycle only.
    task automatic applyStimulus(input int period, input int highCycles, input bit expStep,
                                 input int expOut, input bit expDir);
        for (int i = 0; i < period; i++) begin
            ppIf.tick = (i < highCycles);
            clockCycle();
            checkOutput($sformatf("stepped p%0d c%0d", period, i), 32'(ppIf.stepped), 32'(expStep && i == 0));
            checkOutput($sformatf("out p%0d c%0d", period, i), 32'(ppIf.out), 32'(expOut));
            checkOutput($sformatf("dir p%0d c%0d", period, i), 32'(ppIf.direction), 32'(expDir));
        end
    endtask

    task automatic doReset(input int expMin);
        rstN = 1'b0;
        clockCycle();
        checkOutput("reset out", 32'(ppIf.out), 32'(expMin));
        checkOutput("reset dir", 32'(ppIf.direction), 32'(DIR_UP));
        checkOutput("reset stepped", 32'(ppIf.stepped), 32'd0);
        rstN = 1'b1;
        ppIf.tick = 1'b0;
        clockCycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        rstN        = 1'b0;
        ppIf.tick   = 1'b0;
        ppIf.enable = 1'b1;
        ppIf.flip   = 1'b0;
        ppIf.min    = 4'd0;
        ppIf.max    = 4'd3;

        // Reset and bounce between 0 and 3 at clk/2.
        doReset(0);
        applyStimulus(2, 1, 1, 1, 1);
        applyStimulus(2, 1, 1, 2, 1);
        applyStimulus(2, 1, 1, 3, 1);
        applyStimulus(2, 1, 1, 2, 0);
        applyStimulus(2, 1, 1, 1, 0);
        applyStimulus(2, 1, 1, 0, 0);
        applyStimulus(2, 1, 1, 1, 1);
        applyStimulus(2, 1, 1, 2, 1);

        // Two flip pulses between rises reverse only once; the pending flip is then consumed.
        ppIf.flip = 1'b1;
        clockCycle();
        ppIf.flip = 1'b0;
        clockCycle();
        ppIf.flip = 1'b1;
        clockCycle();
        ppIf.flip = 1'b0;
        checkOutput("flip hold out", 32'(ppIf.out), 32'd2);
        applyStimulus(2, 1, 1, 1, 0);
        applyStimulus(2, 1, 1, 0, 0);

        // Disabled rises and illegal or excluding bounds all hold the count.
        ppIf.enable = 1'b0;
        applyStimulus(2, 1, 0, 0, 0);
        applyStimulus(2, 1, 0, 0, 0);
        applyStimulus(2, 1, 0, 0, 0);
        ppIf.enable = 1'b1;
        ppIf.min    = 4'd5;
        ppIf.max    = 4'd5;
        applyStimulus(2, 1, 0, 0, 0);
        ppIf.max    = 4'd7;
        applyStimulus(2, 1, 0, 0, 0);
        ppIf.min    = 4'd0;
        applyStimulus(2, 1, 1, 1, 1);
        applyStimulus(2, 1, 1, 2, 1);

        // Divider sweep: clk/3 then clk/8 between 2 and 4.
        ppIf.min = 4'd2;
        ppIf.max = 4'd4;
        doReset(2);
        applyStimulus(3, 1, 1, 3, 1);
        applyStimulus(3, 1, 1, 4, 1);
        applyStimulus(3, 1, 1, 3, 0);
        applyStimulus(8, 4, 1, 2, 0);
        applyStimulus(8, 4, 1, 3, 1);
        applyStimulus(2, 1, 1, 4, 1);
        applyStimulus(2, 1, 1, 3, 0);

        // Reset coincident with a tick rise and a flip, then tick held high across release.
        rstN      = 1'b0;
        ppIf.tick = 1'b1;
        ppIf.flip = 1'b1;
        clockCycle();
        checkOutput("midreset out", 32'(ppIf.out), 32'd2);
        checkOutput("midreset dir", 32'(ppIf.direction), 32'(DIR_UP));
        checkOutput("midreset stepped", 32'(ppIf.stepped), 32'd0);
        rstN      = 1'b1;
        ppIf.flip = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clockCycle();
            checkOutput($sformatf("held tick out c%0d", i), 32'(ppIf.out), 32'd2);
            checkOutput($sformatf("held tick stepped c%0d", i), 32'(ppIf.stepped), 32'd0);
        end
        ppIf.tick = 1'b0;
        clockCycle();
        applyStimulus(2, 1, 1, 3, 1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
